// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between fetch and data ports, data-first with fetch anti-starvation
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    output logic              stall_if,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              stall_mem,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              err_spurious_ack
);
    typedef enum logic [1:0] {IDLE, FETCH, DATA, DONE} state_t;
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);
    state_t state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic req_d, we_d, st, st_d, ifr_d, dmr_d, err_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d, ird_d, drd_d;
    assign stall_if  = if_req & ~if_ready;
    assign stall_mem = dm_req & ~dm_ready;
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        req_d   = mem_req;
        we_d    = mem_we;
        st_d    = st;
        addr_d  = mem_addr;
        wdata_d = mem_wdata;
        ird_d   = if_rdata;
        drd_d   = dm_rdata;
        ifr_d   = 1'b0;
        dmr_d   = 1'b0;
        err_d   = err_spurious_ack;
        case (state)
            IDLE: begin
                err_d = err_spurious_ack | mem_ack;
                if (dm_req && (cnt < LIM || !if_req)) begin
                    state_d = DATA;
                    req_d   = 1'b1;
                    we_d    = dm_we;
                    st_d    = dm_we;
                    addr_d  = dm_addr;
                    wdata_d = dm_wdata;
                    cnt_d   = !if_req ? '0 : cnt == LIM ? cnt : cnt + 1'b1;
                end else if (if_req) begin
                    state_d = FETCH;
                    req_d   = 1'b1;
                    we_d    = 1'b0;
                    st_d    = 1'b0;
                    addr_d  = if_addr;
                    cnt_d   = '0;
                end
            end
            FETCH, DATA: begin
                if (mem_ack) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    ifr_d   = state == FETCH;
                    dmr_d   = state == DATA;
                    ird_d   = state == FETCH ? mem_rdata : if_rdata;
                    drd_d   = state == DATA && !st ? mem_rdata : dm_rdata;
                end
            end
            default: begin
                state_d = IDLE;
                err_d   = err_spurious_ack | mem_ack;
            end
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            cnt              <= '0;
            mem_req          <= 1'b0;
            mem_we           <= 1'b0;
            st               <= 1'b0;
            mem_addr         <= '0;
            mem_wdata        <= '0;
            if_rdata         <= '0;
            dm_rdata         <= '0;
            if_ready         <= 1'b0;
            dm_ready         <= 1'b0;
            err_spurious_ack <= 1'b0;
        end else begin
            state            <= state_d;
            cnt              <= cnt_d;
            mem_req          <= req_d;
            mem_we           <= we_d;
            st               <= st_d;
            mem_addr         <= addr_d;
            mem_wdata        <= wdata_d;
            if_rdata         <= ird_d;
            dm_rdata         <= drd_d;
            if_ready         <= ifr_d;
            dm_ready         <= dmr_d;
            err_spurious_ack <= err_d;
        end
    end
endmodule
